dmem_ctrl: RTL
==============

# dmem_ctrl

Sequencer and two-port arbiter in front of the word-organised data memory. It accepts byte, halfword and word load/store requests from the core load/store port (port 0) and from the loader/debug port (port 1), and grants one request at a time with round-robin arbitration. It converts each request into word-wide RAM cycles: read-modify-write for sub-word stores, and lane select plus sign/zero extension for loads. It sits between the execute stage and the data RAM; the RAM holds no funct3 logic.

## Interface
Parameters:
- `DEPTH`, 512: RAM depth in 32-bit words.
- `AW`, `$clog2(DEPTH)`: RAM word-address width (derived).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pN_req_valid`  in  1  request valid (N = 0, 1).
- `pN_req_ready`  out  1  request accepted this cycle.
- `pN_we`  in  1  1 = store, 0 = load.
- `pN_funct3`  in  3  RV32I size/sign code.
- `pN_addr`  in  32  byte address.
- `pN_wdata`  in  32  store data; low byte or halfword used for sub-word stores.
- `pN_rsp_valid`  out  1  one-cycle response strobe.
- `pN_rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `pN_rsp_err`  out  1  misaligned, out-of-range or illegal funct3.
- `mem_en`  out  1  RAM access enable.
- `mem_we`  out  1  RAM write.
- `mem_addr`  out  AW  word index, equal to `addr[AW+1:2]`.
- `mem_wdata`  out  32  RAM write word.
- `mem_rdata`  in  32  RAM read word, valid the cycle after `mem_en & !mem_we`.

## Operation
- **FSM states:** IDLE, LD_WAIT, RMW_WR, RESP.
- **Acceptance:** `pN_req_ready` is high only in IDLE and only for the granted port. Requesters hold `valid` and the payload until `ready`. The controller latches the payload on acceptance.
- **Arbitration:** round-robin over the two ports.
  - If only one port requests, it wins.
  - If both request, the port not granted last wins.
  - After reset, `last` = 1, so port 0 wins the first tie.
- **Decode:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Every other code is an error.
  - Halfword with `addr[0]`=1 is an error.
  - Word with `addr[1:0]`≠0 is an error.
  - `addr` ≥ DEPTH*4 is an error.
- **Error path:** no RAM access. IDLE→RESP with `err`=1 and `rdata`=0.
- **SW:** RAM write issued in the accept cycle. IDLE→RESP.
- **Load:** RAM read issued in the accept cycle. IDLE→LD_WAIT.
  - In LD_WAIT, the controller selects lane `addr[1:0]` (halfword: `addr[1]`), sign- or zero-extends it, and registers the result. LD_WAIT→RESP.
- **SB/SH:** RAM read issued in the accept cycle. IDLE→RMW_WR.
  - In RMW_WR, the controller merges the new byte or halfword into `mem_rdata` at its lane and writes the merged word to the same address. RMW_WR→RESP.
- **RESP:** asserts `pN_rsp_valid` of the owning port for exactly one cycle, then returns to IDLE. No request is accepted in RESP.
- **Port ownership:** only the owning port ever sees `rsp_valid`. `rdata` and `err` are held until the next response.

## Timing
- Accept in cycle T.
  - Error or SW: `rsp_valid` at T+1.
  - Load, SB or SH: `rsp_valid` at T+2.
- Next accept no earlier than the cycle after RESP.
- Throughput: one access per 2 cycles (SW or error) or per 3 cycles (load or sub-word store).
- **Reset values:**
  - State = IDLE, `last` = 1.
  - All `req_ready`, `rsp_valid`, `rsp_err` = 0.
  - `rsp_rdata` = 0.
  - `mem_en`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0.
- **Reset mid-operation:** return to IDLE with no response. A pending RMW write in progress is dropped (`mem_we` = 0 in the reset cycle). The requester must re-issue.
- **Single driver:** `mem_en`/`mem_we` are driven only in the accept cycle and in RMW_WR; both are 0 otherwise.

## Structure
- Package `dmem_pkg` holds:
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The FSM state enum.
  - Pure functions `load_extend(word, addr_lo, funct3)` and `store_merge(old, new, addr_lo, funct3)`.
- One sub-module, `dmem_rr_arb`: a 2-requester round-robin arbiter holding the `last` flag, updated on grant.
- The RAM itself stays a separate instance outside this block.

## Test plan
- Reset, then word 0x10 = 0xDEADBEEF. P0 LB at 0x13 → `rsp_rdata` 0xFFFFFFDE at T+2. LBU at 0x13 → 0x000000DE. LHU at 0x12 → 0x0000DEAD.
- P0 SB 0xA5 at 0x11 onto 0xDEADBEEF → RAM word 0x10 becomes 0xDEADA5EF after RMW_WR; `rsp_valid` at T+2, `err` = 0.
- Both ports request every cycle → grants alternate 0,1,0,1 starting with port 0; each port gets exactly one `rsp_valid` per grant.
- P1 LW at 0x6, SH at 0x3, funct3 011, and addr 0x800 (DEPTH 512) → `err` = 1 at T+1; `mem_en` never asserted.
- SW 0x12345678 at 0x20, then LW 0x20 → 0x12345678. LH 0x22 → 0x00001234.
- `rst` asserted in RMW_WR → no `mem_we`, no `rsp_valid`; state IDLE next cycle; RAM word unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM states
// and the pure lane-handling functions used on the load and store paths.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LD_WAIT,
        ST_RMW_WR,
        ST_RESP
    } state_t;

    // Pick the addressed byte/halfword out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  addr_lo,
                                                input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'h000000, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay the low byte/halfword of new_word onto old_word at its lane.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [1:0]  addr_lo,
                                                input logic [2:0]  funct3);
        logic [31:0] r;
        r = old_word;
        case (funct3[1:0])
            2'b00:   r[{addr_lo, 3'b000} +: 8]       = new_word[7:0];
            2'b01:   r[{addr_lo[1], 4'b0000} +: 16]  = new_word[15:0];
            default: r = new_word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-requester round-robin arbiter. The last-granted flag moves only when a
// grant is actually taken, so an unserved request keeps its priority.
module dmem_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    // Grant the sole requester, or on a tie the port not granted last.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    // Remember which port was served last; reset favours port 0 on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept_i) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory sequencer: arbitrates two load/store ports and turns each request
// into word RAM cycles (read-modify-write for sub-word stores, lane extract for loads).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req_valid,
    output logic          p0_req_ready,
    input  logic          p0_we,
    input  logic [2:0]    p0_funct3,
    input  logic [31:0]   p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_rsp_valid,
    output logic [31:0]   p0_rsp_rdata,
    output logic          p0_rsp_err,
    input  logic          p1_req_valid,
    output logic          p1_req_ready,
    input  logic          p1_we,
    input  logic [2:0]    p1_funct3,
    input  logic [31:0]   p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_rsp_valid,
    output logic [31:0]   p1_rsp_rdata,
    output logic          p1_rsp_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q [2];
    logic [1:0]    err_q;

    logic [1:0]    gnt;
    logic          accept;
    logic          sel;
    logic          sel_we;
    logic [2:0]    sel_f3;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          f3_legal;
    logic          req_err;
    logic          res_we;
    logic          res_port;
    logic [31:0]   res_rdata;
    logic          res_err;

    dmem_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({p1_req_valid, p0_req_valid}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    // Granted port's payload and its decode-time error check.
    always_comb begin
        sel       = gnt[1];
        sel_we    = sel ? p1_we     : p0_we;
        sel_f3    = sel ? p1_funct3 : p0_funct3;
        sel_addr  = sel ? p1_addr   : p0_addr;
        sel_wdata = sel ? p1_wdata  : p0_wdata;
        if (sel_we) begin
            f3_legal = (sel_f3 == F3_B) || (sel_f3 == F3_H) || (sel_f3 == F3_W);
        end else begin
            f3_legal = (sel_f3 == F3_B) || (sel_f3 == F3_H) || (sel_f3 == F3_W) ||
                       (sel_f3 == F3_BU) || (sel_f3 == F3_HU);
        end
        req_err = !f3_legal ||
                  ((sel_f3[1:0] == 2'b01) && sel_addr[0]) ||
                  ((sel_f3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00)) ||
                  (sel_addr >= ADDR_LIMIT);
    end

    // Next state, RAM strobes and response capture; everything is gated off under reset.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        f3_d      = f3_q;
        addr_lo_d = addr_lo_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        accept    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        res_we    = 1'b0;
        res_port  = owner_q;
        res_rdata = '0;
        res_err   = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        accept    = 1'b1;
                        owner_d   = sel;
                        f3_d      = sel_f3;
                        addr_lo_d = sel_addr[1:0];
                        waddr_d   = sel_addr[AW+1:2];
                        wdata_d   = sel_wdata[15:0];
                        res_port  = sel;
                        if (req_err) begin
                            res_we  = 1'b1;
                            res_err = 1'b1;
                            state_d = ST_RESP;
                        end else if (sel_we && (sel_f3 == F3_W)) begin
                            mem_en    = 1'b1;
                            mem_we    = 1'b1;
                            mem_addr  = sel_addr[AW+1:2];
                            mem_wdata = sel_wdata;
                            res_we    = 1'b1;
                            state_d   = ST_RESP;
                        end else begin
                            mem_en   = 1'b1;
                            mem_addr = sel_addr[AW+1:2];
                            state_d  = sel_we ? ST_RMW_WR : ST_LD_WAIT;
                        end
                    end
                end
                ST_LD_WAIT: begin
                    res_we    = 1'b1;
                    res_rdata = load_extend(mem_rdata, addr_lo_q, f3_q);
                    state_d   = ST_RESP;
                end
                ST_RMW_WR: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = waddr_q;
                    mem_wdata = store_merge(mem_rdata, {16'h0000, wdata_q}, addr_lo_q, f3_q);
                    res_we    = 1'b1;
                    state_d   = ST_RESP;
                end
                ST_RESP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and latched request payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            f3_q      <= 3'b000;
            addr_lo_q <= 2'b00;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            f3_q      <= f3_d;
            addr_lo_q <= addr_lo_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Per-port response data/error, held until that port's next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            err_q      <= 2'b00;
        end else if (res_we) begin
            rdata_q[res_port] <= res_rdata;
            err_q[res_port]   <= res_err;
        end
    end

    assign p0_req_ready = !rst && (state_q == ST_IDLE) && gnt[0];
    assign p1_req_ready = !rst && (state_q == ST_IDLE) && gnt[1];
    assign p0_rsp_valid = (state_q == ST_RESP) && !owner_q;
    assign p1_rsp_valid = (state_q == ST_RESP) && owner_q;
    assign p0_rsp_rdata = rdata_q[0];
    assign p1_rsp_rdata = rdata_q[1];
    assign p0_rsp_err   = err_q[0];
    assign p1_rsp_err   = err_q[1];

endmodule
